mux_scan_sequencer: RTL and testbench
=====================================

MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 3, clock cycles allowed for the 4:1 mux path to settle after a select change; legal range 1..15.
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  scan request; sampled only in IDLE.
REQ-005 chan_mask  input  4  enabled channels (bit n = in n); latched when start is accepted.
REQ-006 mux_out  input  1  output of the downstream 4:1 mux (the out of the selector).
REQ-007 sel1  output  1  mux select MSB.
REQ-008 sel0  output  1  mux select LSB.
REQ-009 busy  output  1  high while a scan is in progress (SETTLE state).
REQ-010 samples  output  4  captured mux_out value per channel; bit n = channel n.
REQ-011 samples_valid  output  1  result-available flag.
REQ-012 samples_ready  input  1  consumer acceptance of the result.

Function
REQ-013 The FSM SHALL have the states IDLE, SETTLE and DONE.
REQ-014 In IDLE with start=1 and a nonzero chan_mask, on that edge the FSM SHALL latch the mask, set {sel1,sel0} to the lowest enabled channel, clear samples, load the settle counter and enter SETTLE.
REQ-015 In IDLE with start=1 and chan_mask=0, the FSM SHALL enter DONE on that edge with samples=0.
REQ-016 In SETTLE, on the SETTLE_CYCLES-th rising edge after a select change, the FSM SHALL capture mux_out into samples[current channel].
REQ-017 On that same edge, the FSM SHALL move {sel1,sel0} to the next higher enabled channel and reload the counter; if no enabled channel remains, it SHALL enter DONE instead.
REQ-018 Disabled channels SHALL never be selected, and their samples bits SHALL read 0.
REQ-019 Latency: with N enabled channels, samples_valid SHALL rise exactly N*SETTLE_CYCLES edges after the start-accept edge.
REQ-020 samples_valid SHALL be 1 only in DONE, and samples SHALL be held stable in DONE.
REQ-021 DONE with samples_ready=1 SHALL go to IDLE on that edge, deasserting samples_valid and returning {sel1,sel0} to 00.
REQ-022 start SHALL be ignored in SETTLE and DONE, including when start and samples_ready are both high in the same DONE cycle.
REQ-023 Changes on chan_mask after acceptance SHALL not affect the scan in progress.
REQ-024 busy SHALL be 1 exactly in SETTLE.

Reset
REQ-025 rst_n low SHALL immediately force IDLE: {sel1,sel0}=00, busy=0, samples=0, samples_valid=0, counter=0 and latched mask=0.
REQ-026 A reset that arrives mid-scan SHALL abort the scan with no partial result presented; the first start after reset release SHALL behave per REQ-014.

Configuration
REQ-027 With MUX_SCAN_PARITY_EN defined, the block SHALL add output samples_par (1 bit) = XOR of samples, valid whenever samples_valid=1 and reset to 0.
REQ-028 Without MUX_SCAN_PARITY_EN, the samples_par port and its logic SHALL be absent.

Structure
REQ-029 Package mux_scan_pkg SHALL hold the state encoding (IDLE=2'd0, SETTLE=2'd1, DONE=2'd2), the channel count constant 4 and the select-width constant 2.
REQ-030 The next-enabled-channel search SHALL be implemented as sub-module mux_scan_next_chan (combinational: mask, current channel in -> next channel and found flag out).

Verification
REQ-031 Bench SHALL drive the gate-level 4:1 mux with in0..in3=1,0,1,1, SETTLE_CYCLES=3 and mask 1111 -> sel sequence 00,01,10,11; samples=4'b1101 with valid 12 edges after start.
REQ-032 Mask 0101 -> sel 00 then 10 only; samples bits 1 and 3 = 0; valid 6 edges after start.
REQ-033 Mask 0000 -> valid on the edge after start, samples=0000, busy never high.
REQ-034 samples_ready held low for 20 cycles with start pulses in DONE -> samples and valid stable, starts ignored; ready=1 -> IDLE and sel=00 on the next edge.
REQ-035 rst_n pulsed low 5 cycles into a scan -> outputs zero asynchronously (before the next edge); a subsequent mask-1111 scan completes per REQ-031.
REQ-036 With MUX_SCAN_PARITY_EN defined and samples=1101 -> samples_par=1.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
package mux_scan_pkg;

    localparam int unsigned NUM_CHAN = 4;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } scan_state_t;

endpackage

// File: rtl/mux_scan_next_chan.sv
// Combinational search for the lowest enabled channel strictly above the current one.
module mux_scan_next_chan
    import mux_scan_pkg::*;
(
    input  logic [NUM_CHAN-1:0] i_mask,
    input  logic [SEL_W-1:0]    i_cur,
    output logic [SEL_W-1:0]    o_next,
    output logic                o_found
);

    always_comb begin
        o_next  = '0;
        o_found = 1'b0;
        // Descending walk so the lowest qualifying channel is the last write.
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            if (i > int'(i_cur) && i_mask[i]) begin
                o_next  = SEL_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps a 4:1 mux select across enabled channels, sampling each after a settle delay.
// Optional samples_par output when MUX_SCAN_PARITY_EN is defined.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 3
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [NUM_CHAN-1:0] chan_mask,
    input  logic                mux_out,
    output logic                sel1,
    output logic                sel0,
    output logic                busy,
    output logic [NUM_CHAN-1:0] samples,
    output logic                samples_valid,
    input  logic                samples_ready
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic                samples_par
`endif
);

    // Counter holds remaining edges minus one, so zero marks the capture edge.
    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

    scan_state_t         r_state;
    logic [SEL_W-1:0]    r_sel;
    logic                r_busy;
    logic [NUM_CHAN-1:0] r_samples;
    logic                r_valid;
    logic [3:0]          r_cnt;
    logic [NUM_CHAN-1:0] r_mask;

    logic [SEL_W-1:0]    w_next;
    logic                w_found;
    logic [SEL_W-1:0]    w_above0;
    logic                w_above0_found;
    logic [SEL_W-1:0]    w_first;

    mux_scan_next_chan u_next_chan (
        .i_mask  (r_mask),
        .i_cur   (r_sel),
        .o_next  (w_next),
        .o_found (w_found)
    );

    // Lowest enabled channel of the incoming mask, used when a scan is accepted.
    mux_scan_next_chan u_first_chan (
        .i_mask  (chan_mask),
        .i_cur   ('0),
        .o_next  (w_above0),
        .o_found (w_above0_found)
    );

    assign w_first = chan_mask[0] ? '0 : w_above0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_sel     <= '0;
            r_busy    <= 1'b0;
            r_samples <= '0;
            r_valid   <= 1'b0;
            r_cnt     <= '0;
            r_mask    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_samples <= '0;
                        if (chan_mask != '0) begin
                            r_mask  <= chan_mask;
                            r_sel   <= w_first;
                            r_cnt   <= RELOAD;
                            r_busy  <= 1'b1;
                            r_state <= SETTLE;
                        end else begin
                            r_mask  <= '0;
                            r_valid <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                SETTLE: begin
                    if (r_cnt == '0) begin
                        r_samples[r_sel] <= mux_out;
                        if (w_found) begin
                            r_sel <= w_next;
                            r_cnt <= RELOAD;
                        end else begin
                            r_busy  <= 1'b0;
                            r_valid <= 1'b1;
                            r_state <= DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (samples_ready) begin
                        r_valid <= 1'b0;
                        r_sel   <= '0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sel1          = r_sel[1];
    assign sel0          = r_sel[0];
    assign busy          = r_busy;
    assign samples       = r_samples;
    assign samples_valid = r_valid;

`ifdef MUX_SCAN_PARITY_EN
    assign samples_par = ^r_samples;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer: directed table, corner sequences, random scans.
module tb_mux_scan_sequencer;

    localparam int unsigned SETTLE = 3;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] chan_mask;
    logic [3:0] in_vec;
    logic       mux_out;
    logic       sel1;
    logic       sel0;
    logic       busy;
    logic [3:0] samples;
    logic       samples_valid;
    logic       samples_ready;
`ifdef MUX_SCAN_PARITY_EN
    logic       samples_par;
`endif

    int total = 0;
    int bad   = 0;

    // Gate-level 4:1 mux driven by the DUT selects.
    assign mux_out = (~sel1 & ~sel0 & in_vec[0]) | (~sel1 & sel0 & in_vec[1]) |
                     ( sel1 & ~sel0 & in_vec[2]) | ( sel1 & sel0 & in_vec[3]);

    mux_scan_sequencer #(
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .chan_mask     (chan_mask),
        .mux_out       (mux_out),
        .sel1          (sel1),
        .sel0          (sel0),
        .busy          (busy),
        .samples       (samples),
        .samples_valid (samples_valid),
        .samples_ready (samples_ready)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .samples_par   (samples_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time limit reached, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] mask;
        logic [3:0] inv;
        logic [3:0] exp_samp;
        int         exp_lat;
    } vec_t;

    vec_t tbl [5];

    task automatic run_scan(input logic [3:0] mask, input logic [3:0] inv,
                            input logic [3:0] exp_samp, input int exp_lat, input string tag);
        int         lat;
        int         n_obs;
        int         n_exp;
        logic [7:0] obs_code;
        logic [7:0] exp_code;
        logic [1:0] last_sel;
        logic [3:0] held;
        bit         busy_bad;
        bit         timeout;
        bit         hold_bad;
        int         k;

        // Expected select order: enabled channels, ascending.
        n_exp    = 0;
        exp_code = '0;
        for (int c = 0; c < 4; c++) begin
            if (mask[c]) begin
                exp_code = {exp_code[5:0], 2'(c)};
                n_exp++;
            end
        end

        in_vec    = inv;
        chan_mask = mask;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        chan_mask = ~mask;

        lat      = 0;
        n_obs    = 0;
        obs_code = '0;
        last_sel = 2'b00;
        busy_bad = 1'b0;
        timeout  = 1'b0;
        if (busy) begin
            last_sel = {sel1, sel0};
            obs_code = {obs_code[5:0], last_sel};
            n_obs    = 1;
        end
        if (busy == samples_valid) busy_bad = 1'b1;
        while (!samples_valid && !timeout) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy && {sel1, sel0} != last_sel) begin
                last_sel = {sel1, sel0};
                obs_code = {obs_code[5:0], last_sel};
                n_obs++;
            end
            if (busy == samples_valid) busy_bad = 1'b1;
            if (lat > 200) timeout = 1'b1;
        end

        chk({tag, " timeout"}, 32'(timeout), 32'd0);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " samples"}, 32'(samples), 32'(exp_samp));
        chk({tag, " sel order"}, {16'(n_obs), 8'd0, obs_code}, {16'(n_exp), 8'd0, exp_code});
        chk({tag, " busy xor valid"}, 32'(busy_bad), 32'd0);
`ifdef MUX_SCAN_PARITY_EN
        chk({tag, " parity"}, 32'(samples_par), 32'(^exp_samp));
`endif

        // Hold DONE with stray starts; result must not move.
        held     = samples;
        hold_bad = 1'b0;
        k        = $urandom_range(1, 4);
        for (int i = 0; i < k; i++) begin
            start     = 1'($urandom_range(0, 1));
            chan_mask = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
            if (samples !== held || samples_valid !== 1'b1 || busy !== 1'b0) hold_bad = 1'b1;
        end
        chk({tag, " done hold"}, 32'(hold_bad), 32'd0);

        samples_ready = 1'b1;
        start         = 1'b1;
        @(posedge clk);
        #1;
        samples_ready = 1'b0;
        start         = 1'b0;
        chk({tag, " release"}, {29'd0, samples_valid, busy, (sel1 | sel0)}, 32'd0);
    endtask

    initial begin
        logic [3:0] rm;
        logic [3:0] ri;
        logic [3:0] held;

        tbl[0] = '{mask: 4'b1111, inv: 4'b1101, exp_samp: 4'b1101, exp_lat: 12};
        tbl[1] = '{mask: 4'b0101, inv: 4'b1101, exp_samp: 4'b0101, exp_lat: 6};
        tbl[2] = '{mask: 4'b0000, inv: 4'b1101, exp_samp: 4'b0000, exp_lat: 0};
        tbl[3] = '{mask: 4'b1000, inv: 4'b1111, exp_samp: 4'b1000, exp_lat: 3};
        tbl[4] = '{mask: 4'b0110, inv: 4'b0010, exp_samp: 4'b0010, exp_lat: 6};

        rst_n         = 1'b0;
        start         = 1'b0;
        chan_mask     = 4'b0000;
        in_vec        = 4'b1101;
        samples_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset state", {24'd0, sel1, sel0, busy, samples_valid, samples},
            32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            run_scan(tbl[i].mask, tbl[i].inv, tbl[i].exp_samp, tbl[i].exp_lat,
                     $sformatf("tbl%0d", i));
        end

        // Long DONE stall: 20 cycles of ready low with start pulses.
        in_vec    = 4'b1101;
        chan_mask = 4'b1111;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("stall entry valid", 32'(samples_valid), 32'd1);
        held = samples;
        for (int i = 0; i < 20; i++) begin
            start     = (i % 3 == 0);
            chan_mask = 4'b0011;
            @(posedge clk);
            #1;
            chk("stall hold", {27'd0, samples_valid, busy, samples}, {27'd0, 1'b1, 1'b0, held});
        end
        start         = 1'b0;
        samples_ready = 1'b1;
        @(posedge clk);
        #1;
        samples_ready = 1'b0;
        chk("stall exit", {29'd0, samples_valid, sel1, sel0}, 32'd0);
        @(posedge clk);
        #1;
        chk("idle stays idle", {30'd0, busy, samples_valid}, 32'd0);

        // Reset mid-scan: outputs clear asynchronously, then a clean rescan.
        chan_mask = 4'b1111;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async reset", {24'd0, sel1, sel0, busy, samples_valid, samples}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset idle", {30'd0, busy, samples_valid}, 32'd0);
        run_scan(tbl[0].mask, tbl[0].inv, tbl[0].exp_samp, tbl[0].exp_lat, "after reset");

        for (int i = 0; i < 30; i++) begin
            rm = 4'($urandom_range(0, 15));
            ri = 4'($urandom_range(0, 15));
            run_scan(rm, ri, rm & ri, $countones(rm) * int'(SETTLE), $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
